mips_data_mem_responder: RTL

Data-memory responder for the multicycle MIPS CPU: it answers the CPU's load/store requests over a request/ready handshake with a fixed, parameterised number of wait states. It sits on the responder side of the CPU's RAM interface. It lets the CPU's memory-wait states run against realistic latency rather than a combinational RAM. Storage is a big-endian byte array that supports byte, halfword and word accesses.

---
 rtl/mips_data_mem_responder.sv | 108 ++++++++++
 1 files changed

// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder: wait-stated big-endian byte/half/word data RAM for the multicycle MIPS (ALIGN_ERR_EN enables misalignment errors)
module mips_data_mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_busy,
    output logic        mem_err
);
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [7:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic we_q, we_d, signed_q, signed_d;
    logic [1:0] size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, a0, a1, a2, a3;
    logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, load_val;
    logic is_word, is_half, ext, err, unused_addr;
    assign unused_addr = ^mem_addr[31:ADDR_WIDTH];
    assign is_word = size_q[1];
    assign is_half = size_q == 2'b01;
`ifdef ALIGN_ERR_EN
    assign err = is_half ? addr_q[0] : is_word ? |addr_q[1:0] : 1'b0;
`else
    assign err = 1'b0;
`endif
    // Sub-word accesses ignore the low address bits so bytes stay inside the naturally aligned unit.
    always_comb begin
        a0 = is_word ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : is_half ? {addr_q[ADDR_WIDTH-1:1], 1'b0} : addr_q;
        a1 = a0 + ADDR_WIDTH'(1);
        a2 = a0 + ADDR_WIDTH'(2);
        a3 = a0 + ADDR_WIDTH'(3);
        ext = signed_q & mem[a0][7];
        load_val = is_word ? {mem[a0], mem[a1], mem[a2], mem[a3]} :
                   is_half ? {{16{ext}}, mem[a0], mem[a1]} : {{24{ext}}, mem[a0]};
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        we_d = we_q;
        size_d = size_q;
        signed_d = signed_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && mem_req) begin
            we_d = mem_we;
            size_d = mem_size;
            signed_d = mem_signed;
            addr_d = mem_addr[ADDR_WIDTH-1:0];
            wdata_d = mem_wdata;
            cnt_d = CW'(WAIT_CYCLES);
            state_d = WAIT_CYCLES == 0 ? RESP : WAIT;
        end else if (state_q == WAIT) begin
            state_d = cnt_q == '0 ? RESP : WAIT;
            cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        end else if (state_q == RESP) begin
            state_d = IDLE;
            rdata_d = err ? 32'h0 : we_q ? rdata_q : load_val;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            we_q <= 1'b0;
            size_q <= 2'b00;
            signed_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            we_q <= we_d;
            size_q <= size_d;
            signed_q <= signed_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end
    // Store commits on the RESP exit edge; a coincident reset cancels it.
    always_ff @(posedge clk) begin
        if (!reset && state_q == RESP && we_q && !err) begin
            mem[a0] <= is_word ? wdata_q[31:24] : is_half ? wdata_q[15:8] : wdata_q[7:0];
            if (size_q != 2'b00) mem[a1] <= is_word ? wdata_q[23:16] : wdata_q[7:0];
            if (is_word) begin
                mem[a2] <= wdata_q[15:8];
                mem[a3] <= wdata_q[7:0];
            end
        end
    end
    assign mem_ready = state_q == RESP;
    assign mem_busy = state_q != IDLE;
    assign mem_err = mem_ready & err;
    assign mem_rdata = mem_ready ? rdata_d : rdata_q;
endmodule
